writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Fifth pipeline stage; consumes the memory stage outputs (ALUOutM, read data, WriteRegM, RegWriteM, MemtoRegM).
- Contains the M/W pipeline register, load-data extraction and extension, and the result mux that drives ResultW.
- ResultW, WriteRegW and RegWriteW go to the register file write port and to execute forwarding, replacing the constant-0 ResultW tie-off.
- Adds free-running cycle and retired-instruction counters for bring-up and CPI measurement.

Parameters:
- CNT_WIDTH, 32, width of CycleCount and RetireCount.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- StallW  input  1  hazard unit: hold the M/W register.
- FlushW  input  1  hazard unit: insert a bubble into W.
- ValidM  input  1  M stage holds a real instruction (not a bubble).
- RegWriteM  input  1  control: instruction writes the register file.
- MemtoRegM  input  1  control: result comes from memory read data.
- LoadTypeM  input  3  load width/sign select (codes in package).
- ReadDataM  input  32  data memory read word.
- ALUOutM  input  32  ALU result / effective address.
- WriteRegM  input  5  destination register id.
- RegWriteW  output  1  register file write enable.
- WriteRegW  output  5  register file write id.
- ResultW  output  32  writeback value.
- CycleCount  output  CNT_WIDTH  cycles since reset.
- RetireCount  output  CNT_WIDTH  instructions retired since reset.

Behaviour:
- M/W register updates on rising clock. Precedence: reset > FlushW > StallW > capture.
- Reset and FlushW both clear the M/W register: ValidW, RegWriteW and MemtoRegW = 0; data, id and LoadType = 0.
- Under StallW with no flush, every M/W field holds its value.
- Capture latches ValidM, RegWriteM, MemtoRegM, LoadTypeM, ReadDataM, ALUOutM and WriteRegM.
- Latency: one cycle from M inputs to W outputs. ResultW is combinational from the registered fields; there is no extra register.
- RegWriteW = RegWriteW_reg & ValidW & (WriteRegW != 0). Writes to $0 are never asserted.
- ResultW = MemtoRegW ? LoadExt : ALUOutW.
- Load extraction is big-endian, addressed by ALUOutW[1:0]:
  - Byte at offset 0 is ReadDataW[31:24]; offset 3 is [7:0].
  - Halfword uses ALUOutW[1]: 0 selects [31:16], 1 selects [15:0].
- LoadType codes:
  - WORD=000: no change.
  - LB=001: sign-extend byte.
  - LBU=010: zero-extend byte.
  - LH=011: sign-extend half.
  - LHU=100: zero-extend half.
  - Codes 101–111 behave as WORD.
- Misaligned halfwords/words are not detected; only the low address bits above are used.
- CycleCount: reset to 0, then +1 every cycle, including stalls. Wraps modulo 2^CNT_WIDTH.
- RetireCount: reset to 0. Increments by 1 in any cycle where reset=0, FlushW=0, StallW=0 and ValidM=1, i.e. exactly once per instruction entering W. Wraps modulo 2^CNT_WIDTH.
- Reset mid-operation: all outputs return to their reset values on the next edge. RegWriteW=0 and ResultW=0 from that edge onward.
- Simultaneous StallW and FlushW: the flush wins and RetireCount does not increment.

Decomposition:
- Shared package mips_wb_pkg holds:
  - LoadType code constants (LT_WORD, LT_LB, LT_LBU, LT_LH, LT_LHU).
  - The LoadType width constant.
- Decode control generates LoadTypeM using the same package.
- One natural sub-module: load_extend, purely combinational. Inputs: word, addr[1:0], load type. Output: 32-bit extended value. It is instantiated once in writeback_stage and reusable by a future unaligned-load path.

Test Plan:
- Reset: hold reset 2 cycles with random inputs, then release -> RegWriteW=0, ResultW=0, CycleCount=0 and RetireCount=0 during reset; CycleCount=1 one cycle after release.
- ALU path: ValidM=1, RegWriteM=1, MemtoRegM=0, ALUOutM=0x0000_1234, WriteRegM=8 -> next cycle ResultW=0x0000_1234, WriteRegW=8, RegWriteW=1, RetireCount=1.
- Loads with ReadDataM=0x80FF_7F01:
  - LB at addr …00 -> 0xFFFF_FF80.
  - LBU at addr …01 -> 0x0000_00FF.
  - LH at addr …10 -> 0x0000_7F01.
  - LHU at addr …00 -> 0x0000_80FF.
  - WORD -> 0x80FF_7F01.
- $0 suppression: RegWriteM=1, WriteRegM=0, ValidM=1 -> RegWriteW=0 and RetireCount still increments.
- Stall/flush:
  - Capture value A, then StallW=1 for 3 cycles with B on the inputs -> ResultW stays A, RetireCount unchanged, CycleCount +3.
  - Assert StallW and FlushW together -> RegWriteW=0 next cycle and RetireCount unchanged.
- Counter wrap: CNT_WIDTH=4, 17 cycles after reset -> CycleCount=1. With 16 valid captures -> RetireCount=0.

Source files
------------

// File: rtl/mips_wb_pkg.sv
// Shared writeback-stage definitions: load type codes and the M/W register layout.
package mips_wb_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_ID_W = 5;
    localparam int unsigned LT_W     = 3;

    // Load width/sign select, also driven by decode control.
    localparam logic [LT_W-1:0] LT_WORD = 3'b000;
    localparam logic [LT_W-1:0] LT_LB   = 3'b001;
    localparam logic [LT_W-1:0] LT_LBU  = 3'b010;
    localparam logic [LT_W-1:0] LT_LH   = 3'b011;
    localparam logic [LT_W-1:0] LT_LHU  = 3'b100;

    // M/W pipeline register payload.
    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic                mem_to_reg;
        logic [LT_W-1:0]     load_type;
        logic [DATA_W-1:0]   read_data;
        logic [DATA_W-1:0]   alu_out;
        logic [REG_ID_W-1:0] write_reg;
    } mw_reg_t;

endpackage

// File: rtl/load_extend.sv
// Big-endian byte/halfword extraction and sign/zero extension of a load word.
module load_extend
    import mips_wb_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        addr_i,
    input  logic [LT_W-1:0]   load_type_i,
    output logic [DATA_W-1:0] ext_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Offset 0 is the most significant byte; unknown codes pass the word through.
    always_comb begin
        byte_sel = word_i[31:24];
        half_sel = addr_i[1] ? word_i[15:0] : word_i[31:16];
        ext_c    = word_i;
        case (addr_i)
            2'd0:    byte_sel = word_i[31:24];
            2'd1:    byte_sel = word_i[23:16];
            2'd2:    byte_sel = word_i[15:8];
            default: byte_sel = word_i[7:0];
        endcase
        case (load_type_i)
            LT_LB:   ext_c = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  ext_c = {24'h0, byte_sel};
            LT_LH:   ext_c = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  ext_c = {16'h0, half_sel};
            default: ext_c = word_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: M/W register, load extension, result mux, cycle/retire counters.
module writeback_stage
    import mips_wb_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 StallW,
    input  logic                 FlushW,
    input  logic                 ValidM,
    input  logic                 RegWriteM,
    input  logic                 MemtoRegM,
    input  logic [LT_W-1:0]      LoadTypeM,
    input  logic [DATA_W-1:0]    ReadDataM,
    input  logic [DATA_W-1:0]    ALUOutM,
    input  logic [REG_ID_W-1:0]  WriteRegM,
    output logic                 RegWriteW,
    output logic [REG_ID_W-1:0]  WriteRegW,
    output logic [DATA_W-1:0]    ResultW,
    output logic [CNT_WIDTH-1:0] CycleCount,
    output logic [CNT_WIDTH-1:0] RetireCount
);

    mw_reg_t              mw_q, mw_d;
    logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0] retire_q, retire_d;
    logic [DATA_W-1:0]    load_ext;
    logic                 capture;

    // Next-state: flush beats stall; an instruction retires when it is captured.
    always_comb begin
        mw_d     = mw_q;
        capture  = !FlushW && !StallW;
        cycle_d  = cycle_q + CNT_WIDTH'(1);
        retire_d = retire_q;
        if (FlushW) begin
            mw_d = '0;
        end else if (!StallW) begin
            mw_d.valid      = ValidM;
            mw_d.reg_write  = RegWriteM;
            mw_d.mem_to_reg = MemtoRegM;
            mw_d.load_type  = LoadTypeM;
            mw_d.read_data  = ReadDataM;
            mw_d.alu_out    = ALUOutM;
            mw_d.write_reg  = WriteRegM;
        end
        if (capture && ValidM) begin
            retire_d = retire_q + CNT_WIDTH'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            mw_q     <= '0;
            cycle_q  <= '0;
            retire_q <= '0;
        end else begin
            mw_q     <= mw_d;
            cycle_q  <= cycle_d;
            retire_q <= retire_d;
        end
    end

    load_extend u_load_extend (
        .word_i      (mw_q.read_data),
        .addr_i      (mw_q.alu_out[1:0]),
        .load_type_i (mw_q.load_type),
        .ext_c       (load_ext)
    );

    // Result mux and write enable; $0 is never written.
    always_comb begin
        RegWriteW   = mw_q.reg_write && mw_q.valid && (mw_q.write_reg != '0);
        WriteRegW   = mw_q.write_reg;
        ResultW     = mw_q.mem_to_reg ? load_ext : mw_q.alu_out;
        CycleCount  = cycle_q;
        RetireCount = retire_q;
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: vector table, scoreboard queue, counter model.
module tb_writeback_stage;

    logic        clock = 1'b0;
    logic        reset, StallW, FlushW, ValidM, RegWriteM, MemtoRegM;
    logic [2:0]  LoadTypeM;
    logic [31:0] ReadDataM, ALUOutM;
    logic [4:0]  WriteRegM;

    logic        RegWriteW, rw4;
    logic [4:0]  WriteRegW, wr4;
    logic [31:0] ResultW, res4;
    logic [31:0] CycleCount, RetireCount;
    logic [3:0]  cyc4, ret4;

    int n_vec = 0;
    int n_err = 0;
    int exp_cyc = 0;
    int exp_ret = 0;

    typedef struct {
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] res;
    } wb_exp_t;

    wb_exp_t sb[$];

    typedef struct {
        string       name;
        logic        valid, rw, m2r;
        logic [2:0]  lt;
        logic [31:0] rd, alu;
        logic [4:0]  wr;
        logic        e_rw;
        logic [31:0] e_res;
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    writeback_stage #(.CNT_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .LoadTypeM(LoadTypeM), .ReadDataM(ReadDataM), .ALUOutM(ALUOutM),
        .WriteRegM(WriteRegM), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
        .ResultW(ResultW), .CycleCount(CycleCount), .RetireCount(RetireCount)
    );

    writeback_stage #(.CNT_WIDTH(4)) dut4 (
        .clock(clock), .reset(reset), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .LoadTypeM(LoadTypeM), .ReadDataM(ReadDataM), .ALUOutM(ALUOutM),
        .WriteRegM(WriteRegM), .RegWriteW(rw4), .WriteRegW(wr4),
        .ResultW(res4), .CycleCount(cyc4), .RetireCount(ret4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input logic rw, input logic [4:0] wr, input logic [31:0] res);
        wb_exp_t e;
        e.rw = rw; e.wr = wr; e.res = res;
        sb.push_back(e);
    endtask

    // One clock edge: advance the counter model, then compare counters and any queued W result.
    task automatic tick(input string tag);
        wb_exp_t e;
        if (reset) begin
            exp_cyc = 0;
            exp_ret = 0;
        end else begin
            exp_cyc++;
            if (!FlushW && !StallW && ValidM) exp_ret++;
        end
        @(posedge clock);
        #1;
        chk({tag, ".cycle"},  CycleCount,  32'(exp_cyc));
        chk({tag, ".retire"}, RetireCount, 32'(exp_ret));
        chk({tag, ".cycle4"},  {28'h0, cyc4}, 32'(exp_cyc % 16));
        chk({tag, ".retire4"}, {28'h0, ret4}, 32'(exp_ret % 16));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".rw"},   {31'h0, RegWriteW}, {31'h0, e.rw});
            chk({tag, ".wr"},   {27'h0, WriteRegW}, {27'h0, e.wr});
            chk({tag, ".res"},  ResultW, e.res);
            chk({tag, ".rw4"},  {31'h0, rw4}, {31'h0, e.rw});
            chk({tag, ".res4"}, res4, e.res);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                         input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] wr);
        ValidM = v; RegWriteM = rw; MemtoRegM = m2r; LoadTypeM = lt;
        ReadDataM = rd; ALUOutM = alu; WriteRegM = wr;
    endtask

    task automatic add_vec(input string n, input logic v, input logic rw, input logic m2r,
                           input logic [2:0] lt, input logic [31:0] rd, input logic [31:0] alu,
                           input logic [4:0] wr, input logic e_rw, input logic [31:0] e_res);
        vec_t t;
        t.name = n; t.valid = v; t.rw = rw; t.m2r = m2r; t.lt = lt; t.rd = rd;
        t.alu = alu; t.wr = wr; t.e_rw = e_rw; t.e_res = e_res;
        vecs.push_back(t);
    endtask

    initial begin
        // Expected values written out from the load-extension rules.
        add_vec("alu",      1, 1, 0, 3'b000, 32'hDEAD_BEEF, 32'h0000_1234, 5'd8,  1, 32'h0000_1234);
        add_vec("lb0",      1, 1, 1, 3'b001, 32'h80FF_7F01, 32'h0000_1000, 5'd9,  1, 32'hFFFF_FF80);
        add_vec("lbu1",     1, 1, 1, 3'b010, 32'h80FF_7F01, 32'h0000_1001, 5'd10, 1, 32'h0000_00FF);
        add_vec("lh2",      1, 1, 1, 3'b011, 32'h80FF_7F01, 32'h0000_1002, 5'd11, 1, 32'h0000_7F01);
        add_vec("lhu0",     1, 1, 1, 3'b100, 32'h80FF_7F01, 32'h0000_1000, 5'd12, 1, 32'h0000_80FF);
        add_vec("word",     1, 1, 1, 3'b000, 32'h80FF_7F01, 32'h0000_1000, 5'd13, 1, 32'h80FF_7F01);
        add_vec("lb3",      1, 1, 1, 3'b001, 32'h80FF_7F01, 32'h0000_1003, 5'd14, 1, 32'h0000_0001);
        add_vec("lbu2",     1, 1, 1, 3'b010, 32'h80FF_7F01, 32'h0000_1002, 5'd15, 1, 32'h0000_007F);
        add_vec("lh0",      1, 1, 1, 3'b011, 32'h80FF_7F01, 32'h0000_1000, 5'd16, 1, 32'hFFFF_80FF);
        add_vec("lhu2",     1, 1, 1, 3'b100, 32'h80FF_7F01, 32'h0000_1003, 5'd17, 1, 32'h0000_7F01);
        add_vec("code101",  1, 1, 1, 3'b101, 32'h80FF_7F01, 32'h0000_1001, 5'd18, 1, 32'h80FF_7F01);
        add_vec("code111",  1, 1, 1, 3'b111, 32'h1234_5678, 32'h0000_1003, 5'd19, 1, 32'h1234_5678);
        add_vec("zero_reg", 1, 1, 0, 3'b000, 32'h0,         32'h0000_00AA, 5'd0,  0, 32'h0000_00AA);
        add_vec("bubble",   0, 1, 0, 3'b000, 32'h0,         32'h0000_0055, 5'd7,  0, 32'h0000_0055);
        add_vec("no_write", 1, 0, 0, 3'b000, 32'h0,         32'hCAFE_0000, 5'd21, 0, 32'hCAFE_0000);

        StallW = 0; FlushW = 0;

        // Reset held two cycles with random inputs.
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                  $urandom, $urandom, 5'($urandom));
            StallW = 1'($urandom); FlushW = 1'($urandom);
            expect_wb(0, 5'd0, 32'h0);
            tick("reset");
        end
        reset = 0; StallW = 0; FlushW = 0;
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        expect_wb(0, 5'd0, 32'h0);
        tick("release");
        chk("release.cycle_is_1", CycleCount, 32'd1);

        // Table-driven single captures.
        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].rw, vecs[i].m2r, vecs[i].lt,
                  vecs[i].rd, vecs[i].alu, vecs[i].wr);
            expect_wb(vecs[i].e_rw, vecs[i].wr, vecs[i].e_res);
            tick(vecs[i].name);
        end

        // Stall: capture A, then hold for 3 cycles with B on the inputs.
        drive(1, 1, 0, 3'b000, 32'h0, 32'h0000_00A0, 5'd3);
        expect_wb(1, 5'd3, 32'h0000_00A0);
        tick("stall.capA");
        drive(1, 1, 1, 3'b001, 32'hFFFF_FFFF, 32'h0000_00B0, 5'd4);
        StallW = 1;
        for (int i = 0; i < 3; i++) begin
            expect_wb(1, 5'd3, 32'h0000_00A0);
            tick("stall.hold");
        end

        // Stall and flush together: flush wins, nothing retires.
        FlushW = 1;
        expect_wb(0, 5'd0, 32'h0);
        tick("stall_flush");
        StallW = 0;
        expect_wb(0, 5'd0, 32'h0);
        tick("flush");
        FlushW = 0;
        expect_wb(1, 5'd4, 32'hFFFF_FFFF);
        tick("after_flush");

        // Reset mid-operation with a valid instruction on the inputs.
        reset = 1;
        expect_wb(0, 5'd0, 32'h0);
        tick("mid_reset");

        // Counter wrap at 4 bits: 16 valid captures then one idle cycle.
        reset = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 0, 3'b000, 32'h0, 32'(i), 5'(i + 1));
            expect_wb(1, 5'(i + 1), 32'(i));
            tick("wrap.cap");
        end
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
        tick("wrap.idle");
        chk("wrap.cycle4_is_1",  {28'h0, cyc4}, 32'd1);
        chk("wrap.retire4_is_0", {28'h0, ret4}, 32'd0);
        chk("wrap.retire32_16",  RetireCount,   32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
